// File: rtl/hack_mem_pkg.sv
// Shared definitions for the RAM DMA engine: default widths and the FSM state type.
package hack_mem_pkg;

  localparam int unsigned ADDR_W_DEF = 16;
  localparam int unsigned DATA_W_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WRITE = 3'd2,
    ST_FILL  = 3'd3,
    ST_DONE  = 3'd4
  } dma_state_e;

endpackage

// File: rtl/ram_dma.sv
// ram_dma: copy/fill DMA engine driving a single-port RAM with combinational read.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   start, mode         - request pulse (sampled in IDLE); 0 = copy, 1 = fill
//   src, dst, len       - source base, destination base, word count
//   fill_val            - fill pattern
//   abort               - cancel an active transfer (wins over start in IDLE)
//   mem_address/in/load - RAM address, write data, write enable
//   mem_out             - RAM read data, valid in the same cycle as mem_address
//   busy, done          - transfer active; one-cycle completion pulse
//   words_done          - words written in the current/last transfer
module ram_dma
  import hack_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [ADDR_W-1:0] len,
  input  logic [DATA_W-1:0] fill_val,
  input  logic              abort,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_in,
  output logic              mem_load,
  input  logic [DATA_W-1:0] mem_out,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] words_done
);

  dma_state_e        state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [ADDR_W-1:0] rem_q, rem_d;
  logic [ADDR_W-1:0] words_q, words_d;
  logic [DATA_W-1:0] fill_q, fill_d;
  logic [DATA_W-1:0] data_q, data_d;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      words_q <= '0;
      fill_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      words_q <= words_d;
      fill_q  <= fill_d;
      data_q  <= data_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    words_d = words_q;
    fill_d  = fill_q;
    data_d  = data_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          words_d = '0;
          if (len == '0) begin
            state_d = ST_DONE;
          end else begin
            src_d   = src;
            dst_d   = dst;
            rem_d   = len;
            fill_d  = fill_val;
            state_d = mode ? ST_FILL : ST_READ;
          end
        end
      end
      ST_READ: begin
        data_d  = mem_out;
        state_d = abort ? ST_IDLE : ST_WRITE;
      end
      ST_WRITE: begin
        // The write in this cycle lands even when aborted, so it is counted.
        src_d   = src_q + ADDR_W'(1);
        dst_d   = dst_q + ADDR_W'(1);
        words_d = words_q + ADDR_W'(1);
        rem_d   = rem_q - ADDR_W'(1);
        if (abort)                      state_d = ST_IDLE;
        else if (rem_q == ADDR_W'(1))   state_d = ST_DONE;
        else                            state_d = ST_READ;
      end
      ST_FILL: begin
        dst_d   = dst_q + ADDR_W'(1);
        words_d = words_q + ADDR_W'(1);
        rem_d   = rem_q - ADDR_W'(1);
        if (abort)                      state_d = ST_IDLE;
        else if (rem_q == ADDR_W'(1))   state_d = ST_DONE;
        else                            state_d = ST_FILL;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // RAM port and status decode; depends only on registered state
  always_comb begin
    mem_address = '0;
    mem_in      = '0;
    mem_load    = 1'b0;
    unique case (state_q)
      ST_READ:  mem_address = src_q;
      ST_WRITE: begin
        mem_address = dst_q;
        mem_in      = data_q;
        mem_load    = 1'b1;
      end
      ST_FILL: begin
        mem_address = dst_q;
        mem_in      = fill_q;
        mem_load    = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy       = (state_q == ST_READ) || (state_q == ST_WRITE) || (state_q == ST_FILL);
  assign done       = (state_q == ST_DONE);
  assign words_done = words_q;

endmodule

// File: tb/tb_ram_dma.sv
// Directed testbench for ram_dma with a 16K-word RAM responder (addresses alias on the low 14 bits).
module tb_ram_dma;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, mode, abort;
  logic [15:0] src, dst, len, fill_val;
  logic [15:0] mem_address, mem_in, mem_out, words_done;
  logic        mem_load, busy, done;

  logic [15:0] ram [0:16383];
  logic [15:0] wr_addr [0:255];
  int          wr_cnt = 0;
  int          done_cnt = 0;
  logic        tb_clr = 1'b0, tb_we = 1'b0;
  logic [13:0] tb_a = '0;
  logic [15:0] tb_d = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram_dma dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .src(src), .dst(dst),
    .len(len), .fill_val(fill_val), .abort(abort), .mem_address(mem_address),
    .mem_in(mem_in), .mem_load(mem_load), .mem_out(mem_out), .busy(busy),
    .done(done), .words_done(words_done)
  );

  assign mem_out = ram[mem_address[13:0]];

  // RAM responder with bench-side clear/preload port and a write log
  always @(posedge clk) begin
    if (tb_clr) begin
      for (int i = 0; i < 16384; i++) ram[i] <= '0;
    end else if (tb_we) begin
      ram[tb_a] <= tb_d;
    end else if (mem_load) begin
      ram[mem_address[13:0]] <= mem_in;
      wr_addr[8'(wr_cnt)] <= mem_address;
      wr_cnt <= wr_cnt + 1;
    end
  end

  always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic poke(input logic [13:0] a, input logic [15:0] d);
    @(negedge clk);
    tb_we = 1'b1; tb_a = a; tb_d = d;
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  // Called at a negedge; returns just after the start-sampling edge.
  task automatic start_xfer(input logic m, input logic [15:0] s, input logic [15:0] d,
                            input logic [15:0] l, input logic [15:0] f);
    start = 1'b1; mode = m; src = s; dst = d; len = l; fill_val = f;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int exp_cyc);
    int cyc;
    cyc = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (done) begin cyc = k; break; end
    end
    check(tag, 32'(cyc), 32'(exp_cyc));
  endtask

  initial begin
    int base, dbase;
    rst_n = 1'b0; start = 1'b0; mode = 1'b0; abort = 1'b0;
    src = '0; dst = '0; len = '0; fill_val = '0;
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_load", 32'(mem_load), 0);
    check("rst_addr", 32'(mem_address), 0);
    check("rst_words", 32'(words_done), 0);
    @(negedge clk);
    tb_clr = 1'b1;
    @(negedge clk);
    tb_clr = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // Fill 4 words at 0x0010
    base = wr_cnt;
    start_xfer(1'b1, 16'h0, 16'h0010, 16'd4, 16'hBEEF);
    wait_done("fill_latency", 5);
    @(negedge clk);
    check("fill_done_one_cycle", 32'(done), 0);
    check("fill_words", 32'(words_done), 4);
    check("fill_count", 32'(wr_cnt - base), 4);
    for (int i = 0; i < 4; i++) check("fill_ram", 32'(ram[14'h10 + 14'(i)]), 32'hBEEF);
    check("fill_ram_after", 32'(ram[14'h14]), 0);

    // Copy 2 words 0x0000 -> 0x0100
    poke(14'h0, 16'h002A);
    poke(14'h1, 16'h0064);
    start_xfer(1'b0, 16'h0, 16'h0100, 16'd2, 16'h0);
    wait_done("copy_latency", 5);
    @(negedge clk);
    check("copy_ram0", 32'(ram[14'h100]), 32'h002A);
    check("copy_ram1", 32'(ram[14'h101]), 32'h0064);
    check("copy_words", 32'(words_done), 2);

    // Zero-length request
    base = wr_cnt;
    start_xfer(1'b1, 16'h0, 16'h0200, 16'd0, 16'hFFFF);
    wait_done("len0_latency", 1);
    @(negedge clk);
    check("len0_writes", 32'(wr_cnt - base), 0);
    check("len0_words", 32'(words_done), 0);

    // Copy 8 words, abort after the third write
    base = wr_cnt; dbase = done_cnt;
    start_xfer(1'b0, 16'h0200, 16'h0300, 16'd8, 16'h0);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (wr_cnt - base == 3) break;
    end
    check("abort_reach3", 32'(wr_cnt - base), 3);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(busy), 0);
    check("abort_load", 32'(mem_load), 0);
    repeat (20) @(negedge clk);
    check("abort_writes", 32'(wr_cnt - base), 3);
    check("abort_no_done", 32'(done_cnt - dbase), 0);
    check("abort_words", 32'(words_done), 3);

    // Fill across the top of the address space
    base = wr_cnt;
    start_xfer(1'b1, 16'h0, 16'hFFFE, 16'd4, 16'h1234);
    wait_done("wrap_latency", 5);
    check("wrap_count", 32'(wr_cnt - base), 4);
    check("wrap_a0", 32'(wr_addr[8'(base)]), 32'hFFFE);
    check("wrap_a1", 32'(wr_addr[8'(base + 1)]), 32'hFFFF);
    check("wrap_a2", 32'(wr_addr[8'(base + 2)]), 32'h0000);
    check("wrap_a3", 32'(wr_addr[8'(base + 3)]), 32'h0001);
    check("wrap_ram", 32'(ram[14'h3FFF]), 32'h1234);
    @(negedge clk);

    // Copy 4 words; start pulse while busy, then reset during the second WRITE
    base = wr_cnt;
    start_xfer(1'b0, 16'h0000, 16'h0400, 16'd4, 16'h0);
    @(negedge clk);
    check("busy_c1", 32'(busy), 1);
    start = 1'b1; mode = 1'b1; dst = 16'h0500; len = 16'd1; fill_val = 16'h5555;
    @(negedge clk);
    start = 1'b0;
    check("ign_addr", 32'(mem_address), 32'h0400);
    check("ign_load", 32'(mem_load), 1);
    @(negedge clk);
    check("ign_read_addr", 32'(mem_address), 32'h0001);
    @(negedge clk);
    check("w2_load", 32'(mem_load), 1);
    rst_n = 1'b0;
    #1;
    check("rstw_load", 32'(mem_load), 0);
    check("rstw_addr", 32'(mem_address), 0);
    check("rstw_in", 32'(mem_in), 0);
    check("rstw_busy", 32'(busy), 0);
    check("rstw_words", 32'(words_done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("rstw_writes", 32'(wr_cnt - base), 1);
    check("rstw_ram400", 32'(ram[14'h400]), 32'h1234);
    check("rstw_ram500", 32'(ram[14'h500]), 0);
    check("rstw_idle", 32'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
